// File: rtl/decode_sb.sv
// RV32I/RV32E decode stage with per-register busy scoreboard,
// multi-port writeback forwarding and flush rollback.
module decode_sb #(
   parameter int XLEN     = 32,
   parameter int NREG     = 32,
   parameter int WB_PORTS = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_i,
   output logic                     ready_o,
   input  logic [XLEN-1:0]          pc_i,
   input  logic [31:0]              inst_i,
   output logic [4:0]               rs1num_o,
   output logic [4:0]               rs2num_o,
   input  logic [XLEN-1:0]          rs1data_i,
   input  logic [XLEN-1:0]          rs2data_i,
   input  logic [WB_PORTS-1:0]      wb_valid_i,
   input  logic [WB_PORTS-1:0]      wb_we_i,
   input  logic [5*WB_PORTS-1:0]    wb_rd_i,
   input  logic [XLEN*WB_PORTS-1:0] wb_data_i,
   input  logic                     flush_i,
   output logic                     valid_ro,
   input  logic                     ready_i,
   output logic [XLEN-1:0]          pc_ro,
   output logic [31:0]              inst_ro,
   output logic [XLEN-1:0]          rs1data_ro,
   output logic [XLEN-1:0]          rs2data_ro,
   output logic [XLEN-1:0]          imm_ro,
   output logic                     illegal_ro
);

   localparam logic [6:0] OP_OP  = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_JLR = 7'b1100111;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_AUI = 7'b0010111;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [5:0] NREG_W = 6'(NREG);

   logic [6:0]      opc;
   logic [4:0]      rs1, rs2, rd, rd_ro;
   logic            use1, use2, wr, known, illegal;
   logic            u1, u2, res, res_ro;
   logic [31:0]     imm32;
   logic [XLEN-1:0] imm;
   logic [31:0]     busy, busy_n, rel;
   logic            fwd1, fwd2;
   logic [XLEN-1:0] fd1, fd2, op1, op2;
   logic            cke, hazard, accept;

   assign opc      = inst_i[6:0];
   assign rs1      = inst_i[19:15];
   assign rs2      = inst_i[24:20];
   assign rd       = inst_i[11:7];
   assign rd_ro    = inst_ro[11:7];
   assign rs1num_o = rs1;
   assign rs2num_o = rs2;

   always_comb begin
      use1  = 1'b0;
      use2  = 1'b0;
      wr    = 1'b0;
      known = 1'b1;
      imm32 = '0;
      unique case (1'b1)
         opc == OP_OP: begin
            use1 = 1'b1;
            use2 = 1'b1;
            wr   = 1'b1;
         end
         opc == OP_IMM || opc == OP_LD || opc == OP_JLR: begin
            use1  = 1'b1;
            wr    = 1'b1;
            imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
         end
         opc == OP_ST: begin
            use1  = 1'b1;
            use2  = 1'b1;
            imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
         end
         opc == OP_BR: begin
            use1  = 1'b1;
            use2  = 1'b1;
            imm32 = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25],
                     inst_i[11:8], 1'b0};
         end
         opc == OP_LUI || opc == OP_AUI: begin
            wr    = 1'b1;
            imm32 = {inst_i[31:12], 12'b0};
         end
         opc == OP_JAL: begin
            wr    = 1'b1;
            imm32 = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20],
                     inst_i[30:21], 1'b0};
         end
         default: known = 1'b0;
      endcase
      imm       = {XLEN{imm32[31]}};
      imm[31:0] = imm32;
   end

   assign illegal = ~known
                  | (use1 & ({1'b0, rs1} >= NREG_W))
                  | (use2 & ({1'b0, rs2} >= NREG_W))
                  | (wr   & ({1'b0, rd}  >= NREG_W));
   assign u1  = use1 & ~illegal;
   assign u2  = use2 & ~illegal;
   assign res = wr & ~illegal & (rd != 5'd0);

   // Lowest port wins: the loop runs high to low so port 0 writes last.
   always_comb begin
      rel  = '0;
      fwd1 = 1'b0;
      fwd2 = 1'b0;
      fd1  = '0;
      fd2  = '0;
      for (int k = WB_PORTS - 1; k >= 0; k--) begin
         if (wb_valid_i[k])
            rel[wb_rd_i[5*k +: 5]] = 1'b1;
         if (wb_valid_i[k] && wb_we_i[k]) begin
            if (wb_rd_i[5*k +: 5] == rs1) begin
               fwd1 = 1'b1;
               fd1  = wb_data_i[XLEN*k +: XLEN];
            end
            if (wb_rd_i[5*k +: 5] == rs2) begin
               fwd2 = 1'b1;
               fd2  = wb_data_i[XLEN*k +: XLEN];
            end
         end
      end
   end

   assign op1 = (fwd1 && rs1 != 5'd0) ? fd1 : rs1data_i;
   assign op2 = (fwd2 && rs2 != 5'd0) ? fd2 : rs2data_i;

   assign hazard = valid_i & ((u1 & busy[rs1] & ~rel[rs1])
                            | (u2 & busy[rs2] & ~rel[rs2])
                            | (res & busy[rd] & ~rel[rd]));
   assign cke     = ~valid_ro | ready_i;
   assign accept  = valid_i & cke & ~hazard & ~flush_i;
   assign ready_o = flush_i | (cke & ~hazard);

   // Rollback is applied last so it overrides a release of the same reg.
   always_comb begin
      busy_n = busy & ~rel;
      if (accept && res)
         busy_n[rd] = 1'b1;
      if (flush_i && valid_ro && res_ro)
         busy_n[rd_ro] = 1'b0;
      busy_n[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy       <= '0;
         valid_ro   <= 1'b0;
         pc_ro      <= '0;
         inst_ro    <= '0;
         rs1data_ro <= '0;
         rs2data_ro <= '0;
         imm_ro     <= '0;
         illegal_ro <= 1'b0;
         res_ro     <= 1'b0;
      end else begin
         busy <= busy_n;
         if (flush_i) begin
            valid_ro <= 1'b0;
         end else if (accept) begin
            valid_ro   <= 1'b1;
            pc_ro      <= pc_i;
            inst_ro    <= inst_i;
            rs1data_ro <= op1;
            rs2data_ro <= op2;
            imm_ro     <= imm;
            illegal_ro <= illegal;
            res_ro     <= res;
         end else if (cke) begin
            valid_ro <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_decode_sb.sv
// Directed bench for decode_sb (RV32E, two writeback ports).
module tb_decode_sb;

   localparam int XLEN = 32;
   localparam int WBP  = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             valid_i, ready_o, flush_i, valid_ro, ready_i;
   logic [31:0]      pc_i, inst_i, inst_ro;
   logic [4:0]       rs1num_o, rs2num_o;
   logic [31:0]      rs1data_i, rs2data_i;
   logic [WBP-1:0]   wb_valid_i, wb_we_i;
   logic [5*WBP-1:0] wb_rd_i;
   logic [63:0]      wb_data_i;
   logic [31:0]      pc_ro, rs1data_ro, rs2data_ro, imm_ro;
   logic             illegal_ro;

   int total = 0;
   int bad   = 0;

   decode_sb #(.XLEN(XLEN), .NREG(16), .WB_PORTS(WBP)) dut (
      .clk(clk), .rst(rst),
      .valid_i(valid_i), .ready_o(ready_o),
      .pc_i(pc_i), .inst_i(inst_i),
      .rs1num_o(rs1num_o), .rs2num_o(rs2num_o),
      .rs1data_i(rs1data_i), .rs2data_i(rs2data_i),
      .wb_valid_i(wb_valid_i), .wb_we_i(wb_we_i),
      .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
      .flush_i(flush_i),
      .valid_ro(valid_ro), .ready_i(ready_i),
      .pc_ro(pc_ro), .inst_ro(inst_ro),
      .rs1data_ro(rs1data_ro), .rs2data_ro(rs2data_ro),
      .imm_ro(imm_ro), .illegal_ro(illegal_ro)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] rs1d;
      logic [31:0] imm;
      logic        ill;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      valid_i    = 1'b0;
      flush_i    = 1'b0;
      ready_i    = 1'b1;
      wb_valid_i = '0;
      wb_we_i    = '0;
      wb_rd_i    = '0;
      wb_data_i  = '0;
   endtask

   task automatic drive(input logic [31:0] inst);
      valid_i = 1'b1;
      inst_i  = inst;
   endtask

   // beq xr,x0 reserves nothing; ready_o shows whether xr is busy
   task automatic probe(input int r, input logic exp_rdy);
      logic [31:0] save;
      save       = inst_i;
      valid_i    = 1'b1;
      inst_i     = (32'(r) << 15) | 32'h63;
      #1;
      chk($sformatf("busy_probe_x%0d", r), 32'(ready_o), 32'(exp_rdy));
      valid_i = 1'b0;
      inst_i  = save;
   endtask

   initial begin
      tbl[0]  = '{32'hFFF08013, 32'h0000_1000, 32'h0000_0011, 32'hFFFF_FFFF, 1'b0};
      tbl[1]  = '{32'hFE20AC23, 32'h0000_1004, 32'h0000_0022, 32'hFFFF_FFF8, 1'b0};
      tbl[2]  = '{32'hFE208EE3, 32'h0000_1008, 32'h0000_0033, 32'hFFFF_FFFC, 1'b0};
      tbl[3]  = '{32'h12345037, 32'h0000_100C, 32'h0000_0044, 32'h1234_5000, 1'b0};
      tbl[4]  = '{32'hFFFFF017, 32'h0000_1010, 32'h0000_0055, 32'hFFFF_F000, 1'b0};
      tbl[5]  = '{32'hFFFFF06F, 32'h0000_1014, 32'h0000_0066, 32'hFFFF_FFFE, 1'b0};
      tbl[6]  = '{32'h0020807F, 32'h0000_1018, 32'h0000_0077, 32'h0000_0000, 1'b1};
      tbl[7]  = '{32'h00208A33, 32'h0000_101C, 32'h0000_0088, 32'h0000_0000, 1'b1};
      tbl[8]  = '{32'h00288033, 32'h0000_1020, 32'h0000_0099, 32'h0000_0000, 1'b1};
      tbl[9]  = '{32'h0041A003, 32'h0000_1024, 32'h0000_00AA, 32'h0000_0004, 1'b0};
      tbl[10] = '{32'h01008067, 32'h0000_1028, 32'h0000_00BB, 32'h0000_0010, 1'b0};

      idle();
      inst_i    = '0;
      pc_i      = '0;
      rs1data_i = '0;
      rs2data_i = '0;
      rst       = 1'b1;
      #2;
      chk("rst_valid", 32'(valid_ro), 32'd0);
      chk("rst_pc", pc_ro, 32'd0);
      chk("rst_inst", inst_ro, 32'd0);
      chk("rst_imm", imm_ro, 32'd0);
      chk("rst_rs1d", rs1data_ro, 32'd0);
      chk("rst_illegal", 32'(illegal_ro), 32'd0);
      #1 rst = 1'b0;
      tick();

      // immediates and illegal decode, back-to-back, rd=x0 only
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].inst);
         pc_i      = tbl[i].pc;
         rs1data_i = tbl[i].rs1d;
         tick();
         chk($sformatf("tbl%0d_valid", i), 32'(valid_ro), 32'd1);
         chk($sformatf("tbl%0d_imm", i), imm_ro, tbl[i].imm);
         chk($sformatf("tbl%0d_ill", i), 32'(illegal_ro), 32'(tbl[i].ill));
         chk($sformatf("tbl%0d_pc", i), pc_ro, tbl[i].pc);
         chk($sformatf("tbl%0d_rs1d", i), rs1data_ro, tbl[i].rs1d);
      end
      idle();
      tick();
      chk("drain_valid", 32'(valid_ro), 32'd0);

      // hazard-free pair
      drive(32'h00500093);
      #1 chk("addi1_ready", 32'(ready_o), 32'd1);
      tick();
      chk("addi1_valid", 32'(valid_ro), 32'd1);
      chk("addi1_imm", imm_ro, 32'd5);
      drive(32'h00700113);
      tick();
      chk("addi2_valid", 32'(valid_ro), 32'd1);
      chk("addi2_imm", imm_ro, 32'd7);
      valid_i = 1'b0;
      probe(1, 1'b0);
      probe(2, 1'b0);
      tick();

      // RAW stall, then both ports release with data in the same cycle
      drive(32'h002081B3);
      rs1data_i = 32'hDEAD;
      rs2data_i = 32'hBEEF;
      #1 chk("raw_ready", 32'(ready_o), 32'd0);
      tick();
      chk("raw_stall_valid", 32'(valid_ro), 32'd0);
      wb_valid_i = 2'b11;
      wb_we_i    = 2'b11;
      wb_rd_i    = {5'd2, 5'd1};
      wb_data_i  = {32'h5678, 32'h1234};
      #1 chk("raw_fwd_ready", 32'(ready_o), 32'd1);
      tick();
      chk("raw_valid", 32'(valid_ro), 32'd1);
      chk("raw_rs1d", rs1data_ro, 32'h1234);
      chk("raw_rs2d", rs2data_ro, 32'h5678);
      idle();
      probe(1, 1'b1);
      probe(2, 1'b1);
      probe(3, 1'b0);
      tick();

      // WAW, unblocked by a kill-release; set wins over clear
      drive(32'h000012B7);
      tick();
      chk("lui1_valid", 32'(valid_ro), 32'd1);
      drive(32'h000022B7);
      #1 chk("waw_ready", 32'(ready_o), 32'd0);
      tick();
      chk("waw_stall_valid", 32'(valid_ro), 32'd0);
      wb_valid_i = 2'b01;
      wb_we_i    = 2'b00;
      wb_rd_i    = {5'd0, 5'd5};
      #1 chk("waw_kill_ready", 32'(ready_o), 32'd1);
      tick();
      chk("lui2_valid", 32'(valid_ro), 32'd1);
      chk("lui2_imm", imm_ro, 32'h2000);
      idle();
      probe(5, 1'b0);
      tick();

      // kill-release x5 and x3 on separate ports
      wb_valid_i = 2'b11;
      wb_rd_i    = {5'd3, 5'd5};
      tick();
      idle();
      probe(5, 1'b1);
      probe(3, 1'b1);

      // flush rolls back the jal x1 held in the output register
      drive(32'h008000EF);
      pc_i = 32'h100;
      tick();
      chk("jal_valid", 32'(valid_ro), 32'd1);
      chk("jal_imm", imm_ro, 32'd8);
      chk("jal_pc", pc_ro, 32'h100);
      ready_i = 1'b0;
      drive(32'h00100213);
      flush_i = 1'b1;
      #1 chk("flush_ready", 32'(ready_o), 32'd1);
      tick();
      chk("flush_valid", 32'(valid_ro), 32'd0);
      idle();
      probe(1, 1'b1);
      probe(4, 1'b1);

      // illegal opcode with rd=x6 must not reserve
      drive(32'h0000037F);
      tick();
      chk("ill_valid", 32'(valid_ro), 32'd1);
      chk("ill_flag", 32'(illegal_ro), 32'd1);
      valid_i = 1'b0;
      probe(6, 1'b1);
      tick();

      // async reset in the middle of a stall
      drive(32'h00100393);
      tick();
      chk("addi7_valid", 32'(valid_ro), 32'd1);
      ready_i = 1'b0;
      drive(32'h00038433);
      #1 chk("stall_ready", 32'(ready_o), 32'd0);
      tick();
      chk("stall_hold_valid", 32'(valid_ro), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_valid", 32'(valid_ro), 32'd0);
      chk("rst_mid_ready", 32'(ready_o), 32'd1);
      #1 rst = 1'b0;
      idle();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decode_sb.md
# decode_sb

Parametrised in-order decode stage for the RV32I pipeline, sitting between fetch and execute. It owns a per-register busy scoreboard, which the previous decode stage did not have. Other features:
- Generates sign-extended immediates.
- Forwards results from multiple writeback ports.
- Supports pipeline flush with reservation rollback.
- Parametrised in data width, register count (RV32I or RV32E) and writeback port count.

## Interface
Parameters:
- XLEN, 32, data/PC width; must be ≥32; immediates sign-extend to XLEN.
- NREG, 32, architectural register count; 32 (RV32I) or 16 (RV32E).
- WB_PORTS, 1, number of writeback/release channels (1..4).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- valid_i  in  1  fetch offers pc_i/inst_i.
- ready_o  out  1  decode accepts this cycle.
- pc_i  in  XLEN  instruction PC.
- inst_i  in  32  instruction word.
- rs1num_o, rs2num_o  out  5 each  register-file read addresses, combinational from inst_i[19:15] and inst_i[24:20].
- rs1data_i, rs2data_i  in  XLEN each  combinational register-file read data.
- wb_valid_i  in  WB_PORTS  release of busy bit wb_rd_i[k].
- wb_we_i  in  WB_PORTS  release carries a result; without it, the release is a kill-release with no data.
- wb_rd_i  in  5*WB_PORTS  released register numbers, port k at [5k+4:5k].
- wb_data_i  in  XLEN*WB_PORTS  result data per port.
- flush_i  in  1  kill the output register and the current input.
- valid_ro  out  1  execute payload valid.
- ready_i  in  1  execute accepts.
- pc_ro, rs1data_ro, rs2data_ro, imm_ro  out  XLEN each  registered payload.
- inst_ro  out  32  registered instruction.
- illegal_ro  out  1  unknown opcode, or register index ≥ NREG.

## Operation
Decode classes by opcode; each class determines rs1/rs2 use, rd reservation and immediate format.
- OP (0110011): uses rs1 and rs2; reserves rd; no immediate.
- OPIMM (0010011), LOAD (0000011), JALR (1100111): use rs1; reserve rd; I-immediate.
- STORE (0100011): uses rs1 and rs2; S-immediate.
- BRANCH (1100011): uses rs1 and rs2; B-immediate.
- LUI (0110111), AUIPC (0010111): reserve rd; U-immediate.
- JAL (1101111): reserves rd; J-immediate.
- Any other opcode, or any used register index ≥ NREG: illegal. An illegal instruction uses no registers and reserves nothing, but still passes downstream with illegal_ro=1.
- rd reservation is suppressed when rd = x0.

Scoreboard:
- busy[NREG-1:0]. Bit 0 is constantly 0.
- rel[r]: set when any port k has wb_valid_i[k] and wb_rd_i[k]=r.
- fwd[r]: set when rel[r] holds and that port also has wb_we_i; the lowest matching k supplies the data.

Hazards:
- RAW: a used rs has busy[rs] & ~rel[rs].
- WAW: the instruction reserves rd and busy[rd] & ~rel[rd].
- hazard = valid_i & (RAW | WAW).

Handshake:
- cke = ~valid_ro | ready_i.
- accept = valid_i & cke & ~hazard & ~flush_i.
- ready_o = flush_i | (cke & ~hazard). During flush, the input is consumed and dropped.

Operand select per source: fwd[rs] ? wb_data_i[k] : rs*data_i.

Scoreboard update each cycle:
- Clear every rel bit.
- Then set busy[rd] on an accept that reserves rd. Set wins over clear on the same register.
- On flush_i with valid_ro and inst_ro reserving rd: clear busy[rd of inst_ro]. This rollback wins over a same-cycle release of the same register.

Output register:
- On accept: valid_ro←1 and the full payload loads.
- On cke & ~accept: valid_ro←0 and the payload holds.
- On ~cke: everything holds.
- On flush_i: valid_ro←0. A valid_ro & ready_i coincident with flush_i is not a transfer; execute ignores it.

## Timing
- Reset: valid_ro=0; pc_ro, inst_ro, rs1data_ro, rs2data_ro, imm_ro = 0; illegal_ro=0; busy all 0.
- Latency: 1 cycle from accept to valid_ro.
- Throughput: 1 instruction/cycle when hazard-free and ready_i=1.
- ready_o and the rs*num_o outputs are combinational from inst_i, valid_i, busy, the wb_* inputs, valid_ro, ready_i and flush_i. The payload path from wb_data_i is combinational into the registers.
- A release in cycle N unblocks a dependent instruction in the same cycle N (zero-bubble forwarding).
- A back-to-back dependent pair with no writeback in between stalls until the release arrives.
- Reset asserted mid-stall clears all busy bits and drops valid_ro immediately.

## Test plan
- Hazard-free stream: addi x1,x0,5 then addi x2,x0,7, ready_i=1. Expected: valid_ro on consecutive cycles; imm_ro=5, then 7; busy[1] and busy[2] set.
- RAW stall: add x3,x1,x2 while busy[1]. Expected: ready_o=0. Then wb_valid/we on port 0 with rd=1, data=0x1234 in the same cycle. Expected: accepted that cycle; rs1data_ro=0x1234.
- WAW plus kill-release: lui x5 twice. Expected: the second stalls. Then wb_valid=1, wb_we=0, rd=5. Expected: the second is accepted; busy[5] stays 1 (set wins).
- Flush rollback: jal x1 in the output register, ready_i=0, flush_i=1. Expected: next cycle valid_ro=0, busy[1]=0, input dropped.
- Immediates/illegal: beq offset -4. Expected: imm_ro=0xFFFFFFFC. opcode 0x7F. Expected: illegal_ro=1, no reservation.
- NREG=16, WB_PORTS=2: add x20,x1,x2. Expected: illegal_ro=1. Both ports releasing different registers in one cycle. Expected: both busy bits clear.
